conv_dispatch: RTL and testbench

CONV_DISPATCH -- requirements
Module: conv_dispatch

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_dispatch_if.sv | 58 +++++
 rtl/dispatch_chan.sv | 177 +++++++++++++++++
 rtl/conv_dispatch.sv | 62 ++++++
 tb/tb_conv_dispatch.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the convolution operand dispatcher.
//   chan_state_e    : per-channel prefetch state (IDLE, PRIME, STREAM)
//   DISPATCH_DEPTH  : depth of each channel's prefetch FIFO
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int DISPATCH_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } chan_state_e;

endpackage

// File: rtl/conv_dispatch_if.sv
// -----------------------------------------------------------------------------
// conv_dispatch_if
// Bundles every non-clock/reset signal of conv_dispatch.
//   control  : start, cfg_ifm_len, cfg_wgt_len
//   consumer : ifm_read/ifm_group, wgt_read/wgt_group, ready, ifm_wrap,
//              wgt_wrap, err_underflow
//   memory   : {ifm,wgt}_mem_en, {ifm,wgt}_mem_addr, {ifm,wgt}_mem_rdata
//   debug    : ifm_state, wgt_state (channel FSM state)
// Consumer handshake: ready is the "valid" of the stream. A cycle with
// *_read high and the channel streaming is a pop; the group is presented
// combinationally in that same cycle and is 0 in every non-pop cycle.
// Memory handshake: *_mem_en is a request with fixed 1-cycle latency; the
// memory must return *_mem_rdata in the cycle after the request, no stalls.
// -----------------------------------------------------------------------------
interface conv_dispatch_if #(
  parameter int IFM_WIDTH = 80,
  parameter int WGT_WIDTH = 24,
  parameter int AWIDTH    = 16
);
  import conv_pkg::*;

  logic                 start;
  logic [AWIDTH-1:0]    cfg_ifm_len;
  logic [AWIDTH-1:0]    cfg_wgt_len;
  logic                 ifm_read;
  logic                 wgt_read;
  logic [IFM_WIDTH-1:0] ifm_group;
  logic [WGT_WIDTH-1:0] wgt_group;
  logic                 ifm_mem_en;
  logic                 wgt_mem_en;
  logic [AWIDTH-1:0]    ifm_mem_addr;
  logic [AWIDTH-1:0]    wgt_mem_addr;
  logic [IFM_WIDTH-1:0] ifm_mem_rdata;
  logic [WGT_WIDTH-1:0] wgt_mem_rdata;
  logic                 ready;
  logic                 ifm_wrap;
  logic                 wgt_wrap;
  logic                 err_underflow;
  chan_state_e          ifm_state;
  chan_state_e          wgt_state;

  modport slave (
    input  start, cfg_ifm_len, cfg_wgt_len, ifm_read, wgt_read,
           ifm_mem_rdata, wgt_mem_rdata,
    output ifm_group, wgt_group, ifm_mem_en, wgt_mem_en,
           ifm_mem_addr, wgt_mem_addr, ready, ifm_wrap, wgt_wrap,
           err_underflow, ifm_state, wgt_state
  );

  modport master (
    output start, cfg_ifm_len, cfg_wgt_len, ifm_read, wgt_read,
           ifm_mem_rdata, wgt_mem_rdata,
    input  ifm_group, wgt_group, ifm_mem_en, wgt_mem_en,
           ifm_mem_addr, wgt_mem_addr, ready, ifm_wrap, wgt_wrap,
           err_underflow, ifm_state, wgt_state
  );

endinterface

// File: rtl/dispatch_chan.sv
// -----------------------------------------------------------------------------
// dispatch_chan
// One operand channel: cyclic address generator, 1-cycle-latency memory
// requester and a 2-entry prefetch FIFO with zero-latency pop.
// Optional feature: define DISPATCH_UNDERFLOW_CHK_EN to compile in sticky
// underflow detection (read while nothing is available); otherwise err_o is
// tied to 0.
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset
//   start_i       : restart pulse, samples cfg_len_i
//   cfg_len_i     : groups per pass (>= 1)
//   read_i        : pop request
//   group_o       : popped group (0 when not popping)
//   mem_en_o      : memory read request
//   mem_addr_o    : memory group address
//   mem_rdata_i   : memory data, valid the cycle after mem_en_o
//   wrap_o        : pulses on the pop of the last group of a pass
//   err_o         : sticky underflow flag
//   state_o       : FSM state (debug)
// -----------------------------------------------------------------------------
module dispatch_chan
  import conv_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] cfg_len_i,
  input  logic              read_i,
  output logic [WIDTH-1:0]  group_o,
  output logic              mem_en_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  input  logic [WIDTH-1:0]  mem_rdata_i,
  output logic              wrap_o,
  output logic              err_o,
  output chan_state_e       state_o
);

  localparam logic [AWIDTH-1:0] ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]        FULL = 2'(DISPATCH_DEPTH);

  chan_state_e       state_q, state_d;
  logic [AWIDTH-1:0] len_q;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              inflight_q;
  logic              infl_last_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              rd_ptr_q, wr_ptr_q;
  logic [WIDTH-1:0]  data_q [DISPATCH_DEPTH];
  logic              last_q [DISPATCH_DEPTH];

  logic              avail;
  logic              pop;
  logic              push;
  logic              issue;
  logic              issue_last;
  logic [2:0]        occ;

  // Data is only handed out once the channel is primed; a start cycle
  // never pops because the FIFO is being flushed.
  assign avail      = (state_q == STREAM) && (cnt_q != 2'd0);
  assign pop        = read_i && avail && !start_i;
  // rdata is captured whenever a request was made last cycle; a start in
  // that cycle throws the returning data away.
  assign push       = inflight_q && !start_i;
  assign issue_last = (addr_q == (len_q - ONE));
  assign occ        = {1'b0, cnt_q} + {2'b00, inflight_q};
  // Issue when stored + outstanding, less this cycle's pop, stays below 2.
  assign issue      = (state_q != IDLE) && !start_i &&
                      (occ < (3'd2 + {2'b00, pop}));

  assign mem_en_o   = issue;
  assign mem_addr_o = addr_q;
  assign group_o    = pop ? data_q[rd_ptr_q] : '0;
  assign wrap_o     = pop && last_q[rd_ptr_q];
  assign state_o    = state_q;

  always_comb begin
    addr_d = addr_q;
    if (start_i) begin
      addr_d = '0;
    end else if (issue) begin
      addr_d = issue_last ? '0 : (addr_q + ONE);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = 2'd0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = PRIME;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        PRIME:   if (cnt_d == FULL) state_d = STREAM;
        STREAM:  state_d = STREAM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      len_q       <= ONE;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      last_q[0]   <= 1'b0;
      last_q[1]   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      inflight_q  <= issue;
      infl_last_q <= issue_last;
      if (start_i) begin
        len_q    <= cfg_len_i;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        if (push) begin
          wr_ptr_q         <= ~wr_ptr_q;
          last_q[wr_ptr_q] <= infl_last_q;
        end
      end
    end
  end

  // Payload storage needs no reset: an entry is only read after a push.
  always_ff @(posedge clk) begin
    if (push) data_q[wr_ptr_q] <= mem_rdata_i;
  end

`ifdef DISPATCH_UNDERFLOW_CHK_EN
  logic underflow;
  logic err_q;

  assign underflow = read_i && !avail && !start_i;
  assign err_o     = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (start_i) begin
      err_q <= 1'b0;
    end else if (underflow) begin
      err_q <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      assert (!underflow) else $error("dispatch_chan: read with no group available");
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/conv_dispatch.sv
// -----------------------------------------------------------------------------
// conv_dispatch
// Feeds a convolution engine with input-feature-map and weight groups from
// two independent prefetching channels (dispatch_chan x2).
// Optional feature: DISPATCH_UNDERFLOW_CHK_EN enables sticky underflow
// detection inside each channel; err_underflow is 0 when it is undefined.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : conv_dispatch_if.slave -- control, consumer pops, both
//               memory ports, ready/wrap/error status, debug channel states
// -----------------------------------------------------------------------------
module conv_dispatch
  import conv_pkg::*;
#(
  parameter int IFM_WIDTH = 80,
  parameter int WGT_WIDTH = 24,
  parameter int AWIDTH    = 16
) (
  input logic               clk,
  input logic               rstn,
  conv_dispatch_if.slave    bus
);

  logic ifm_err;
  logic wgt_err;

  dispatch_chan #(.WIDTH(IFM_WIDTH), .AWIDTH(AWIDTH)) u_ifm_chan (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (bus.start),
    .cfg_len_i   (bus.cfg_ifm_len),
    .read_i      (bus.ifm_read),
    .group_o     (bus.ifm_group),
    .mem_en_o    (bus.ifm_mem_en),
    .mem_addr_o  (bus.ifm_mem_addr),
    .mem_rdata_i (bus.ifm_mem_rdata),
    .wrap_o      (bus.ifm_wrap),
    .err_o       (ifm_err),
    .state_o     (bus.ifm_state)
  );

  dispatch_chan #(.WIDTH(WGT_WIDTH), .AWIDTH(AWIDTH)) u_wgt_chan (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (bus.start),
    .cfg_len_i   (bus.cfg_wgt_len),
    .read_i      (bus.wgt_read),
    .group_o     (bus.wgt_group),
    .mem_en_o    (bus.wgt_mem_en),
    .mem_addr_o  (bus.wgt_mem_addr),
    .mem_rdata_i (bus.wgt_mem_rdata),
    .wrap_o      (bus.wgt_wrap),
    .err_o       (wgt_err),
    .state_o     (bus.wgt_state)
  );

  // Channels never leave STREAM except through start or reset, so the AND
  // of the two states holds ready high until then.
  assign bus.ready         = (bus.ifm_state == STREAM) && (bus.wgt_state == STREAM);
  assign bus.err_underflow = ifm_err | wgt_err;

endmodule

// File: tb/tb_conv_dispatch.sv
module tb_conv_dispatch;
  import conv_pkg::*;

  localparam int IW = 80;
  localparam int WW = 24;
  localparam int AW = 16;

  logic clk;
  logic rstn;

  conv_dispatch_if #(.IFM_WIDTH(IW), .WGT_WIDTH(WW), .AWIDTH(AW)) dif ();

  conv_dispatch #(.IFM_WIDTH(IW), .WGT_WIDTH(WW), .AWIDTH(AW)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dif.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] exp_q [$];
  bit            expw_q [$];

  int ifm_next, wgt_next, ifm_len_m, wgt_len_m;
  int w_iss, w_pops, w_viol;
  bit w_pop_now;
  bit exp_err;
  int k;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference data ----------------
  function automatic logic [IW-1:0] ifm_pat(input int a);
    logic [IW-1:0] r;
    r = '0;
    for (int b = 0; b < IW / 8; b++) r[b*8 +: 8] = 8'(a + b);
    return r;
  endfunction

  function automatic logic [WW-1:0] wgt_pat(input int a);
    logic [WW-1:0] r;
    r = '0;
    for (int b = 0; b < WW / 8; b++) r[b*8 +: 8] = 8'(a + 64 * b);
    return r;
  endfunction

  // ---------------- memory responder: 1-cycle latency ----------------
  always @(posedge clk) begin
    if (dif.ifm_mem_en) dif.ifm_mem_rdata <= ifm_pat(int'(dif.ifm_mem_addr));
    if (dif.wgt_mem_en) dif.wgt_mem_rdata <= wgt_pat(int'(dif.wgt_mem_addr));
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tracks stored + outstanding wgt groups from observed requests and the
  // pops the stimulus asked for.
  task automatic mon();
    if (!rstn || dif.start) begin
      w_iss  = 0;
      w_pops = 0;
    end else begin
      if (dif.wgt_mem_en) w_iss++;
      if (w_pop_now) w_pops++;
      if (w_iss - w_pops > 2) w_viol++;
    end
  endtask

  task automatic tick();
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic ifm_pop(input string tag);
    logic [IW-1:0] e;
    bit            ew;
    exp_q.push_back(ifm_pat(ifm_next));
    expw_q.push_back(ifm_next == ifm_len_m - 1);
    ifm_next = (ifm_next + 1) % ifm_len_m;
    dif.ifm_read = 1'b1;
    settle();
    e  = exp_q.pop_front();
    ew = expw_q.pop_front();
    chk({tag, "_group"}, dif.ifm_group, e);
    chk({tag, "_wrap"}, {79'd0, dif.ifm_wrap}, {79'd0, ew});
  endtask

  task automatic wait_ready(input string tag);
    k = 0;
    while (!dif.ready && k < 10) begin
      tick();
      settle();
      k++;
    end
    chk(tag, {79'd0, dif.ready}, 80'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    dif.start       = 1'b0;
    dif.cfg_ifm_len = '0;
    dif.cfg_wgt_len = '0;
    dif.ifm_read    = 1'b0;
    dif.wgt_read    = 1'b0;
    rstn            = 1'b0;
    w_iss = 0; w_pops = 0; w_viol = 0; w_pop_now = 1'b0;
`ifdef DISPATCH_UNDERFLOW_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // reset values
    #3;
    chk("rst_ready",    {79'd0, dif.ready},         80'd0);
    chk("rst_ifm_en",   {79'd0, dif.ifm_mem_en},    80'd0);
    chk("rst_wgt_en",   {79'd0, dif.wgt_mem_en},    80'd0);
    chk("rst_ifm_addr", {64'd0, dif.ifm_mem_addr},  80'd0);
    chk("rst_wgt_addr", {64'd0, dif.wgt_mem_addr},  80'd0);
    chk("rst_err",      {79'd0, dif.err_underflow}, 80'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tick();
    chk("idle_no_en", {79'd0, dif.ifm_mem_en | dif.wgt_mem_en}, 80'd0);

    // first start: ifm_len=4, wgt_len=3
    dif.start = 1'b1;
    dif.cfg_ifm_len = 16'd4;
    dif.cfg_wgt_len = 16'd3;
    ifm_len_m = 4; wgt_len_m = 3; ifm_next = 0; wgt_next = 0;
    settle();
    chk("start_cyc_en", {79'd0, dif.ifm_mem_en}, 80'd0);
    tick();
    dif.start = 1'b0;
    settle();
    chk("first_ifm_en",   {79'd0, dif.ifm_mem_en},   80'd1);
    chk("first_ifm_addr", {64'd0, dif.ifm_mem_addr}, 80'd0);
    chk("first_wgt_en",   {79'd0, dif.wgt_mem_en},   80'd1);
    chk("first_ready",    {79'd0, dif.ready},        80'd0);
    wait_ready("ready_after_start");
    chk("ready_latency", {79'd0, (k >= 2 && k <= 3)}, 80'd1);
    tick();

    // continuous ifm pops: 0,1,2,3,0,1,2,3,0,1
    for (int i = 0; i < 10; i++) begin
      ifm_pop("ifm_stream");
      chk("ifm_stream_wgt_zero", {56'd0, dif.wgt_group}, 80'd0);
      chk("ifm_stream_err", {79'd0, dif.err_underflow}, 80'd0);
      tick();
    end
    dif.ifm_read = 1'b0;

    // wgt pops on alternate cycles: 0,1,2,0,1 with zeros in between
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        exp_q.push_back({56'd0, wgt_pat(wgt_next)});
        expw_q.push_back(wgt_next == wgt_len_m - 1);
        wgt_next = (wgt_next + 1) % wgt_len_m;
        dif.wgt_read = 1'b1;
        w_pop_now = 1'b1;
        settle();
        chk("wgt_toggle_group", {56'd0, dif.wgt_group}, exp_q.pop_front());
        chk("wgt_toggle_wrap", {79'd0, dif.wgt_wrap}, {79'd0, expw_q.pop_front()});
      end else begin
        dif.wgt_read = 1'b0;
        w_pop_now = 1'b0;
        settle();
        chk("wgt_idle_group", {56'd0, dif.wgt_group}, 80'd0);
        chk("wgt_idle_wrap", {79'd0, dif.wgt_wrap}, 80'd0);
      end
      tick();
    end
    dif.wgt_read = 1'b0;
    w_pop_now = 1'b0;

    // keep ifm streaming so a request is outstanding when start arrives
    for (int i = 0; i < 3; i++) begin
      ifm_pop("ifm_pre_restart");
      tick();
    end

    // restart mid-stream with ifm_len=2
    dif.ifm_read = 1'b0;
    dif.start = 1'b1;
    dif.cfg_ifm_len = 16'd2;
    ifm_len_m = 2; ifm_next = 0;
    settle();
    chk("restart_cyc_ready", {79'd0, dif.ready}, 80'd1);
    tick();
    dif.start = 1'b0;
    dif.ifm_read = 1'b1;
    settle();
    chk("restart_ready_drop", {79'd0, dif.ready},         80'd0);
    chk("early_read_group",   dif.ifm_group,              80'd0);
    tick();
    dif.ifm_read = 1'b0;
    settle();
    chk("early_read_err",     {79'd0, dif.err_underflow}, {79'd0, exp_err});
    tick();
    settle();
    chk("early_read_err_held", {79'd0, dif.err_underflow}, {79'd0, exp_err});
    wait_ready("ready_after_restart");
    tick();
    for (int i = 0; i < 4; i++) begin
      ifm_pop("ifm_restart");
      tick();
    end

    // asynchronous reset mid-stream
    dif.ifm_read = 1'b1;
    settle();
    rstn = 1'b0;
    #1;
    chk("arst_ready",    {79'd0, dif.ready},                    80'd0);
    chk("arst_ifm_grp",  dif.ifm_group,                         80'd0);
    chk("arst_en",       {79'd0, dif.ifm_mem_en | dif.wgt_mem_en}, 80'd0);
    chk("arst_ifm_addr", {64'd0, dif.ifm_mem_addr},             80'd0);
    chk("arst_wrap",     {79'd0, dif.ifm_wrap | dif.wgt_wrap},  80'd0);
    chk("arst_err",      {79'd0, dif.err_underflow},            80'd0);
    dif.ifm_read = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("post_rst_no_en", {79'd0, dif.ifm_mem_en | dif.wgt_mem_en}, 80'd0);
      chk("post_rst_ready", {79'd0, dif.ready}, 80'd0);
      tick();
    end

    chk("wgt_occupancy", 80'(w_viol), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
